// File: rtl/upload_pkg.sv
// upload_pkg: shared definitions for the Memory upload reader.
//   HDR_BYTES        - length of the sample-count header in bytes
//   SAMPLE_BYTES_DEF - default bytes per audio sample
//   state_t          - upload_reader FSM states
package upload_pkg;

    localparam int HDR_BYTES        = 2;
    localparam int SAMPLE_BYTES_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_DONE,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/sample_assembler.sv
// sample_assembler: shifts upload bytes MSB first into a sample and presents
// completed samples through a single valid/ready holding register.
//   dclk, RST   - clock, asynchronous active-high reset
//   shift_en    - accept din into the assembly register
//   clear       - discard any partially assembled sample
//   din         - upload byte
//   sample_rdy  - downstream accepts when sample_vld & sample_rdy
//   sample      - completed sample, stable while valid and not ready
//   sample_vld  - holding register occupied
//   at_last     - next accepted byte completes a sample
//   stall       - the byte after this cycle would complete a sample while the
//                 holding register is still occupied; used to drop the
//                 registered read request one cycle ahead
module sample_assembler
    import upload_pkg::*;
#(
    parameter int SAMPLE_BYTES = SAMPLE_BYTES_DEF
) (
    input  logic                      dclk,
    input  logic                      RST,
    input  logic                      shift_en,
    input  logic                      clear,
    input  logic [7:0]                din,
    input  logic                      sample_rdy,
    output logic [8*SAMPLE_BYTES-1:0] sample,
    output logic                      sample_vld,
    output logic                      at_last,
    output logic                      stall
);

    localparam int W  = 8 * SAMPLE_BYTES;
    localparam int IW = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLE_BYTES - 1);

    logic [W-9:0]  shreg;
    logic [W-1:0]  assembled;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_n;
    logic          load;
    logic          vld_n;

    assign at_last   = (idx == LAST_IDX);
    assign load      = shift_en & at_last;
    assign assembled = {shreg, din};

    always_comb begin
        idx_n = idx;
        if (clear) begin
            idx_n = '0;
        end else if (shift_en) begin
            idx_n = at_last ? '0 : idx + 1'b1;
        end
        vld_n = load | (sample_vld & ~sample_rdy);
        stall = vld_n & (idx_n == LAST_IDX);
    end

    always_ff @(posedge dclk or posedge RST) begin
        if (RST) begin
            shreg      <= '0;
            idx        <= '0;
            sample     <= '0;
            sample_vld <= 1'b0;
        end else begin
            idx        <= idx_n;
            sample_vld <= vld_n;
            if (shift_en) begin
                shreg <= assembled[W-9:0];
            end
            if (load) begin
                sample <= assembled;
            end
        end
    end

endmodule

// File: rtl/upload_reader.sv
// upload_reader: consumer end of the Memory upload port. Reads a 2-byte
// sample-count header, then reassembles SAMPLE_BYTES-wide samples and
// streams them out on valid/ready, flagging framing and ACK-timeout errors.
//   IFCLK, RST             - clock, asynchronous active-high reset
//   START                  - begin a transaction (held pending while UPBSY)
//   UPBSY/UPRD/UPACK/UPDATA/EOF - Memory upload handshake
//   COUNT                  - header sample count of current/last transaction
//   SAMPLE/SAMPLE_VLD/SAMPLE_RDY - output sample stream
//   BUSY, DONE, ERR        - transaction status
module upload_reader
    import upload_pkg::*;
#(
    parameter int SAMPLE_BYTES = SAMPLE_BYTES_DEF,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic                      IFCLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic                      UPBSY,
    output logic                      UPRD,
    input  logic                      UPACK,
    input  logic [7:0]                UPDATA,
    input  logic                      EOF,
    output logic [8*HDR_BYTES-1:0]    COUNT,
    output logic [8*SAMPLE_BYTES-1:0] SAMPLE,
    output logic                      SAMPLE_VLD,
    input  logic                      SAMPLE_RDY,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      ERR
);

    localparam int CW = 8 * HDR_BYTES;

    state_t        state;
    logic          start_pend;
    logic [CW-1:0] remaining;
    logic [15:0]   to_cnt;
    logic [CW-1:0] hdr_count;
    logic          take;
    logic          start_go;
    logic          to_hit;
    logic          final_smp;
    logic          asm_shift;
    logic          asm_clear;
    logic          at_last;
    logic          stall;

    always_comb begin
        take      = UPRD & UPACK;
        start_go  = (state == ST_IDLE) & (START | start_pend) & ~UPBSY;
        to_hit    = (ACK_TIMEOUT != 0) && UPRD && !UPACK &&
                    (to_cnt == 16'(ACK_TIMEOUT - 1));
        final_smp = (remaining == CW'(1));
        hdr_count = {COUNT[CW-1:8], UPDATA};
        asm_shift = 1'b0;
        asm_clear = start_go | to_hit;
        // An EOF that does not close the final sample discards the partial
        // sample instead of shifting the byte in.
        if (state == ST_DATA && take) begin
            if (EOF && !(at_last && final_smp)) begin
                asm_clear = 1'b1;
            end else begin
                asm_shift = 1'b1;
            end
        end
    end

    sample_assembler #(
        .SAMPLE_BYTES (SAMPLE_BYTES)
    ) u_asm (
        .dclk       (IFCLK),
        .RST        (RST),
        .shift_en   (asm_shift),
        .clear      (asm_clear),
        .din        (UPDATA),
        .sample_rdy (SAMPLE_RDY),
        .sample     (SAMPLE),
        .sample_vld (SAMPLE_VLD),
        .at_last    (at_last),
        .stall      (stall)
    );

    always_ff @(posedge IFCLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            start_pend <= 1'b0;
            remaining  <= '0;
            to_cnt     <= '0;
            UPRD       <= 1'b0;
            COUNT      <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (UPACK) begin
                to_cnt <= '0;
            end else if (UPRD) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (to_hit) begin
                ERR    <= 1'b1;
                UPRD   <= 1'b0;
                BUSY   <= 1'b0;
                to_cnt <= '0;
                state  <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_go) begin
                            state      <= ST_HDR_HI;
                            BUSY       <= 1'b1;
                            UPRD       <= 1'b1;
                            ERR        <= 1'b0;
                            start_pend <= 1'b0;
                            to_cnt     <= '0;
                        end else if (START) begin
                            start_pend <= 1'b1;
                        end
                    end
                    ST_HDR_HI: begin
                        UPRD <= ~UPBSY;
                        if (take) begin
                            COUNT[CW-1:8] <= UPDATA;
                            if (EOF) begin
                                ERR   <= 1'b1;
                                UPRD  <= 1'b0;
                                BUSY  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_HDR_LO;
                            end
                        end
                    end
                    ST_HDR_LO: begin
                        UPRD <= ~UPBSY;
                        if (take) begin
                            COUNT[7:0] <= UPDATA;
                            remaining  <= hdr_count;
                            if (hdr_count == '0) begin
                                if (EOF) begin
                                    UPRD  <= 1'b0;
                                    state <= ST_DONE;
                                end else begin
                                    ERR   <= 1'b1;
                                    state <= ST_FLUSH;
                                end
                            end else if (EOF) begin
                                ERR   <= 1'b1;
                                UPRD  <= 1'b0;
                                BUSY  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        UPRD <= ~UPBSY & ~stall;
                        if (take) begin
                            if (at_last) begin
                                remaining <= remaining - 1'b1;
                            end
                            if (at_last && final_smp) begin
                                if (EOF) begin
                                    UPRD  <= 1'b0;
                                    state <= ST_DONE;
                                end else begin
                                    ERR   <= 1'b1;
                                    UPRD  <= ~UPBSY;
                                    state <= ST_FLUSH;
                                end
                            end else if (EOF) begin
                                ERR   <= 1'b1;
                                UPRD  <= 1'b0;
                                BUSY  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_DONE: begin
                        // Completion waits for the last sample to leave the
                        // holding register.
                        UPRD <= 1'b0;
                        if (!SAMPLE_VLD || SAMPLE_RDY) begin
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                    ST_FLUSH: begin
                        UPRD <= ~UPBSY;
                        if (take && EOF) begin
                            UPRD  <= 1'b0;
                            BUSY  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/upload_reader.md
Name: upload_reader

Overview:
- Consumer end of the Memory upload port: drives UPRD and takes bytes from UPDATA qualified by UPACK.
- Parses the 2-byte sample-count header, then reassembles the following bytes into SAMPLE_BYTES-wide audio samples.
- Presents samples on a valid/ready stream toward the USB/host packetizer, in the IFCLK domain.
- Flags framing errors: EOF versus header-count mismatch, and ACK timeout.

Parameters:
SAMPLE_BYTES, 3, bytes per audio sample, MSB first; SAMPLE width = 8*SAMPLE_BYTES.
ACK_TIMEOUT, 255, max consecutive UPRD-high cycles without UPACK before abort; 0 disables.

Ports:
IFCLK  in  1  clock, all logic on rising edge.
RST  in  1  asynchronous, active-high reset.
START  in  1  one-cycle pulse, begins one upload transaction; ignored unless BUSY=0.
UPBSY  in  1  Memory busy; UPRD is not raised while high.
UPRD  out  1  read request to Memory.
UPACK  in  1  UPDATA holds a valid byte this cycle.
UPDATA  in  8  upload byte.
EOF  in  1  Memory marks the final byte of the transaction; sampled only with UPACK.
COUNT  out  16  header sample count of current/last transaction.
SAMPLE  out  8*SAMPLE_BYTES  reassembled sample.
SAMPLE_VLD  out  1  SAMPLE valid.
SAMPLE_RDY  in  1  downstream accepts when VLD&RDY.
BUSY  out  1  transaction in progress.
DONE  out  1  one-cycle pulse at clean completion.
ERR  out  1  sticky framing/timeout error, cleared by next START.

Behaviour:
- Reset values: UPRD=0, COUNT=0, SAMPLE=0, SAMPLE_VLD=0, BUSY=0, DONE=0, ERR=0, state=IDLE, counters=0.
- Byte transfer: a byte is consumed on a rising edge where UPRD=1 and UPACK=1. UPACK with UPRD=0 is ignored.
- States:
  - IDLE: on START and UPBSY=0, go to HDR_HI with BUSY=1 and UPRD=1 from the next cycle. START with UPBSY=1 is held pending until UPBSY=0.
  - HDR_HI: byte -> COUNT[15:8].
  - HDR_LO: byte -> COUNT[7:0].
    - COUNT==0 with EOF: DONE.
    - COUNT==0 without EOF: ERR, then FLUSH.
    - Otherwise: DATA.
  - DATA:
    - Shift bytes MSB first into the assembly register; byte index wraps 0..SAMPLE_BYTES-1.
    - On the last byte, load SAMPLE and set SAMPLE_VLD the next cycle; decrement the remaining-sample counter.
  - DONE: BUSY=0, DONE pulse for one cycle, return to IDLE.
  - FLUSH: keep UPRD=1 and discard bytes until EOF is consumed, then go to IDLE with BUSY=0 and no DONE.
- EOF rules in DATA:
  - EOF on the last byte of the last sample: clean completion.
  - EOF anywhere else: ERR=1, the partial sample is discarded, go to IDLE.
  - Final sample byte consumed without EOF: ERR=1, go to FLUSH.
- Backpressure: one output holding register.
  - While SAMPLE_VLD=1 and SAMPLE_RDY=0, and the next byte would complete a sample, UPRD drops combinationally-registered (next cycle).
  - No byte is ever lost. SAMPLE is stable while VLD&!RDY.
  - Full throughput is one byte/cycle when RDY stays high.
- DONE ordering: DONE is asserted only after the last sample has been accepted (VLD&RDY).
- Timeout: a counter increments each cycle with UPRD=1 and UPACK=0 and resets on any UPACK. Reaching ACK_TIMEOUT -> ERR=1, UPRD=0, IDLE.
- Simultaneous START while BUSY: ignored.
- RST mid-transaction: immediate return to reset values; the partial sample is discarded.
- Widths: remaining-sample counter is 16 bits; byte index is clog2(SAMPLE_BYTES) bits.

Decomposition:
- Shared package upload_pkg: the state encoding enum, HDR_BYTES=2, and the default SAMPLE_BYTES.
- One natural sub-module, sample_assembler: byte shift register, index counter and output holding register with valid/ready. The FSM and counters stay in the top.

Test Plan:
1. COUNT=2 (header 00 02), bytes 01 02 03 04 05 06 with EOF on 06, RDY=1 -> SAMPLE 010203 then 040506, COUNT=0002, DONE one pulse, ERR=0, UPRD low after EOF.
2. Same stream with RDY=0 for 10 cycles after the first sample -> UPRD drops, SAMPLE holds 010203, no byte lost; 040506 follows once RDY=1.
3. Header 00 03, EOF on the 5th data byte -> ERR=1, no third sample, BUSY=0, no DONE; next START clears ERR.
4. Header 00 01, 3 data bytes without EOF, then 2 more bytes with EOF on the last -> one sample, ERR=1, FLUSH consumes both bytes, IDLE.
5. UPRD high with UPACK held low 255 cycles (ACK_TIMEOUT=255) -> ERR=1 on cycle 255, UPRD=0, IDLE.
6. RST pulsed mid-DATA after 4 bytes -> all outputs at reset values asynchronously; next START with header 00 01 and bytes 0A 0B 0C + EOF -> SAMPLE 0A0B0C, DONE.
